// File: rtl/sensor_monitor_if.sv
// Bus bundle between the sensor-bank scan controller and its user.
// The slave side is the monitor; the master side drives enable/sensors/ack.
interface sensor_monitor_if #(
   parameter int unsigned CNT_W = 8
);
   logic             enable;
   logic [3:0]       sensors;
   logic             ack;
   logic             alarm;
   logic             sample_strobe;
   logic [CNT_W-1:0] error_count;

   modport master (
      output enable, sensors, ack,
      input  alarm, sample_strobe, error_count
   );

   modport slave (
      input  enable, sensors, ack,
      output alarm, sample_strobe, error_count
   );
endinterface

// File: rtl/sensor_monitor.sv
// Periodic scan controller for the 4-bit sensor bank: synchronise, sample
// every PERIOD cycles, debounce the error condition and latch an alarm.
module sensor_monitor #(
   parameter int unsigned PERIOD   = 8,
   parameter int unsigned DEBOUNCE = 3,
   parameter int unsigned CNT_W    = 8
) (
   input  logic            clk,
   input  logic            n_rst,
   sensor_monitor_if.slave bus
);
   localparam int unsigned PRE_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int unsigned STK_W = $clog2(DEBOUNCE + 1);

   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PERIOD - 1);
   localparam logic [STK_W-1:0] STK_MAX = STK_W'(DEBOUNCE);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_MONITOR = 2'd1;
   localparam logic [1:0] S_CONFIRM = 2'd2;
   localparam logic [1:0] S_ALARM   = 2'd3;

   logic [3:0]       r_sync1;
   logic [3:0]       r_sync2;
   logic [PRE_W-1:0] r_presc;
   logic             r_strobe;
   logic [1:0]       r_state;
   logic [STK_W-1:0] r_streak;
   logic [CNT_W-1:0] r_err_cnt;
   logic             r_alarm;

   logic             w_err;
   logic             w_tick;
   logic [1:0]       w_state_nxt;
   logic [STK_W-1:0] w_streak_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;

   // Two-flop synchroniser per sensor bit
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= bus.sensors;
         r_sync2 <= r_sync1;
      end
   end

   assign w_err  = r_sync2[0] | (r_sync2[1] & (r_sync2[2] | r_sync2[3]));
   assign w_tick = bus.enable & (r_presc == PRE_MAX);

   // Sample-rate prescaler, parked at zero while scanning is disabled
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_presc  <= '0;
         r_strobe <= 1'b0;
      end else begin
         r_strobe <= w_tick;
         if (!bus.enable || (r_presc == PRE_MAX)) begin
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + PRE_W'(1);
         end
      end
   end

   // Debounce / alarm state machine: next-state, streak and event count
   always_comb begin
      w_state_nxt  = r_state;
      w_streak_nxt = r_streak;
      w_cnt_nxt    = r_err_cnt;

      case (r_state)
         S_IDLE: begin
            w_streak_nxt = '0;
            if (bus.enable) begin
               w_state_nxt = S_MONITOR;
            end
         end
         S_MONITOR: begin
            if (!bus.enable) begin
               w_state_nxt  = S_IDLE;
               w_streak_nxt = '0;
            end else if (w_tick && w_err) begin
               w_streak_nxt = STK_W'(1);
               w_state_nxt  = (DEBOUNCE == 1) ? S_ALARM : S_CONFIRM;
            end
         end
         S_CONFIRM: begin
            if (!bus.enable) begin
               w_state_nxt  = S_IDLE;
               w_streak_nxt = '0;
            end else if (w_tick) begin
               if (w_err) begin
                  w_streak_nxt = r_streak + STK_W'(1);
                  if (w_streak_nxt == STK_MAX) begin
                     w_state_nxt = S_ALARM;
                  end
               end else begin
                  w_streak_nxt = '0;
                  w_state_nxt  = S_MONITOR;
               end
            end
         end
         S_ALARM: begin
            // Ack has priority over any coincident tick; the tick is dropped
            if (bus.ack) begin
               w_streak_nxt = '0;
               w_state_nxt  = bus.enable ? S_MONITOR : S_IDLE;
            end
         end
         default: begin
            w_state_nxt  = S_IDLE;
            w_streak_nxt = '0;
         end
      endcase

      if ((w_state_nxt == S_ALARM) && (r_state != S_ALARM) && (r_err_cnt != CNT_MAX)) begin
         w_cnt_nxt = r_err_cnt + CNT_W'(1);
      end
   end

   // Alarm register tracks the next state so it rises with the ALARM state itself
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state   <= S_IDLE;
         r_streak  <= '0;
         r_err_cnt <= '0;
         r_alarm   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_streak  <= w_streak_nxt;
         r_err_cnt <= w_cnt_nxt;
         r_alarm   <= (w_state_nxt == S_ALARM);
      end
   end

   assign bus.alarm         = r_alarm;
   assign bus.sample_strobe = r_strobe;
   assign bus.error_count   = r_err_cnt;
endmodule

// File: doc/sensor_monitor.md
Name: sensor_monitor

Overview:
- Periodic scan controller for the 4-bit sensor bank; owns sampling cadence, debounce and alarm handling for the sensor error condition.
- Synchronises the raw sensors and samples them every PERIOD cycles. A sampled error must persist for DEBOUNCE consecutive samples before a latched alarm is raised.
- The alarm holds until acknowledged. Confirmed error events are counted for the status logic.

Parameters:
- PERIOD, 8, clock cycles between samples; legal range >= 2.
- DEBOUNCE, 3, consecutive erroring samples required to raise the alarm; legal range >= 1.
- CNT_W, 8, width of the saturating error-event counter.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- enable  input  1  level; 1 = scanning active.
- sensors  input  4  raw asynchronous sensor inputs.
- ack  input  1  alarm acknowledge; level sampled each cycle.
- alarm  output  1  latched confirmed-error indication.
- sample_strobe  output  1  one-cycle pulse per sample taken.
- error_count  output  CNT_W  number of confirmed error events, saturating.

Behaviour:
- Reset (asynchronous, n_rst=0):
  - Synchroniser flops, prescaler and streak counter = 0.
  - FSM = IDLE; alarm = 0; sample_strobe = 0; error_count = 0.
- Synchroniser: 2-flop on each sensor bit, giving 2-cycle latency. All logic uses the synchronised value s.
- Error condition: err = s[0] | (s[1] & (s[2] | s[3])). Example: 4'b0010 gives no error; 4'b0110 and 4'b0001 give an error.
- Prescaler:
  - Counts 0..PERIOD-1 and wraps while enable=1.
  - Held at 0 while enable=0.
  - tick = enable & (prescaler == PERIOD-1).
- sample_strobe: registered copy of tick, high for the one cycle after the tick cycle.
- FSM, all transitions on the clock edge ending the stated cycle:
  - IDLE: enable=1 -> MONITOR. Streak = 0.
  - MONITOR:
    - tick & err: streak = 1; go to ALARM if DEBOUNCE==1, else CONFIRM.
    - tick & !err: stay.
  - CONFIRM:
    - tick & err: streak + 1; on reaching DEBOUNCE -> ALARM.
    - tick & !err: streak = 0 -> MONITOR.
    - No tick: hold.
  - ALARM:
    - alarm = 1, decoded from the registered state with no extra latency.
    - ack=1 -> MONITOR if enable=1, else IDLE. Streak = 0; a new event needs a fresh full debounce.
    - Ticks are ignored while in ALARM.
  - enable=0 in MONITOR or CONFIRM -> IDLE next edge, streak cleared.
  - enable=0 in ALARM: stay in ALARM until ack.
- error_count: +1 on every transition into ALARM; saturates at 2^CNT_W-1; cleared only by reset.
- ack outside ALARM is ignored.
- Simultaneous tick and ack in ALARM: ack wins and the tick is discarded.
- Reset mid-operation: all state returns to reset values immediately, including alarm and error_count.

Test Plan:
1. Reset, then idle with enable=0 and sensors=4'b1111 for 50 cycles -> alarm=0, sample_strobe never pulses, error_count=0.
2. PERIOD=4, DEBOUNCE=3, enable=1 from cycle 0, sensors=4'b0001 stable -> ticks at cycles 3/7/11; alarm=1 from cycle 12; error_count=1; sample_strobe high at cycles 4/8/12.
3. Error-condition coverage, sensors held for 4 ticks each:
   - 4'b0010 -> no alarm.
   - 4'b1010 -> alarm.
   - 4'b0100 -> no alarm.
   - 4'b0110 -> alarm.
   Pulse ack between cases; count ends at 2.
4. Debounce break: sensors=4'b0001 for 2 ticks, then 4'b0000 for 1 tick, then 4'b0001 for 2 ticks -> no alarm. A third consecutive erroring tick -> alarm.
5. Ack and enable interaction:
   - In ALARM, drop enable -> alarm stays 1.
   - Pulse ack -> IDLE, alarm=0 next cycle.
   - Re-enable with the error still present -> alarm again only after DEBOUNCE more ticks.
6. CNT_W=2 with 5 confirmed events (ack after each) -> error_count reads 1, 2, 3, 3, 3. Assert n_rst mid-ALARM -> alarm=0 and error_count=0 immediately.
